// File: rtl/pdua_io_pkg.sv
// Shared definitions for the peripheral-port UART: register offsets, STATUS
// bit positions, TX/RX state encodings and the default baud divisor.
package pdua_io_pkg;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_BAUD   = 2'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_TX_EMPTY = 1;
  localparam int unsigned ST_TX_BUSY  = 2;
  localparam int unsigned ST_RX_VALID = 3;
  localparam int unsigned ST_RX_OVR   = 4;

  localparam logic [7:0] DIV_RESET_DEFAULT = 8'd15;

  typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  // Half of one bit period, (div+1)>>1, computed without overflow at div=255.
  function automatic logic [7:0] half_period(input logic [7:0] div);
    logic [8:0] period;
    period = {1'b0, div} + 9'd1;
    return period[8:1];
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with extra pointer MSB for full/empty distinction.
// A pop on a full FIFO frees the slot for a push in the same cycle.
module io_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; contents are discarded on reset by clearing both pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART on the peripheral port with a TX FIFO.
// Define UART_RX_EN to build the receive path; otherwise RX reads as zero.
module io_uart
  import pdua_io_pkg::*;
#(
  parameter logic [7:0]  BASE_ADDR  = 8'hF0,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [7:0]  DIV_RESET  = DIV_RESET_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr_bus_pr,
  input  logic [7:0] wr_data_pr,
  input  logic       wr_rdn_pr,
  output logic [7:0] rd_data_pr,
  input  logic       uart_rx,
  output logic       uart_tx
);

  logic       hit;
  logic [1:0] off;
  logic       we;
  logic       we_q;
  logic       wr_stb;
  logic [7:0] baud_div;
  logic       fifo_push;
  logic       fifo_pop;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  tx_state_e  tx_state;
  logic [7:0] tx_cnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_sh;
  logic       tx_bit_end;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ovr;
  logic [7:0] status;

  assign hit    = (addr_bus_pr[7:2] == BASE_ADDR[7:2]);
  assign off    = addr_bus_pr[1:0];
  assign we     = wr_rdn_pr & hit;
  // Only the first cycle of a multi-cycle write acts.
  assign wr_stb = we & ~we_q;

  // Write-edge history and the baud divisor register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q     <= 1'b0;
      baud_div <= DIV_RESET;
    end else begin
      we_q <= we;
      if (wr_stb && off == OFF_BAUD) baud_div <= wr_data_pr;
    end
  end

  assign fifo_push  = wr_stb && (off == OFF_TXDATA);
  assign tx_bit_end = (tx_cnt == 8'd0);
  assign fifo_pop   = ~fifo_empty && ((tx_state == TxIdle) || (tx_state == TxStop && tx_bit_end));

  io_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (wr_data_pr),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // TX framing FSM; the divisor is reloaded at each bit start, so a new
  // BAUD_DIV value is picked up at the next bit boundary.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TxIdle;
      tx_cnt   <= 8'd0;
      tx_bit   <= 3'd0;
      tx_sh    <= 8'd0;
      uart_tx  <= 1'b1;
    end else begin
      unique case (tx_state)
        TxIdle: begin
          if (!fifo_empty) begin
            tx_sh    <= fifo_rdata;
            tx_cnt   <= baud_div;
            uart_tx  <= 1'b0;
            tx_state <= TxStart;
          end
        end
        TxStart: begin
          if (tx_bit_end) begin
            uart_tx  <= tx_sh[0];
            tx_sh    <= {1'b0, tx_sh[7:1]};
            tx_bit   <= 3'd0;
            tx_cnt   <= baud_div;
            tx_state <= TxData;
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        TxData: begin
          if (tx_bit_end) begin
            tx_cnt <= baud_div;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TxStop;
            end else begin
              uart_tx <= tx_sh[0];
              tx_sh   <= {1'b0, tx_sh[7:1]};
              tx_bit  <= tx_bit + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
        TxStop: begin
          if (tx_bit_end) begin
            if (!fifo_empty) begin
              // Back-to-back frame, no idle gap.
              tx_sh    <= fifo_rdata;
              tx_cnt   <= baud_div;
              uart_tx  <= 1'b0;
              tx_state <= TxStart;
            end else begin
              tx_state <= TxIdle;
            end
          end else begin
            tx_cnt <= tx_cnt - 8'd1;
          end
        end
      endcase
    end
  end

`ifdef UART_RX_EN
  logic       rx_s1;
  logic       rx_s2;
  logic       rx_prev;
  rx_state_e  rx_state;
  logic [7:0] rx_cnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_sh;
  logic [7:0] rx_half;
  logic       clr_valid;
  logic       clr_ovr;

  assign rx_half   = half_period(baud_div);
  assign clr_valid = wr_stb && (off == OFF_STATUS) && wr_data_pr[ST_RX_VALID];
  assign clr_ovr   = wr_stb && (off == OFF_STATUS) && wr_data_pr[ST_RX_OVR];

  // Two-flop synchroniser plus one history flop for falling-edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX framing FSM and holding register; a new byte beats a same-cycle W1C.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RxIdle;
      rx_cnt   <= 8'd0;
      rx_bit   <= 3'd0;
      rx_sh    <= 8'd0;
      rx_data  <= 8'd0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
    end else begin
      if (clr_valid) rx_valid <= 1'b0;
      if (clr_ovr)   rx_ovr   <= 1'b0;
      unique case (rx_state)
        RxIdle: begin
          if (rx_prev && !rx_s2) begin
            // With a one-cycle bit the edge sample already is mid-start.
            if (rx_half == 8'd0) begin
              rx_cnt   <= baud_div;
              rx_bit   <= 3'd0;
              rx_state <= RxData;
            end else begin
              rx_cnt   <= rx_half - 8'd1;
              rx_state <= RxStart;
            end
          end
        end
        RxStart: begin
          if (rx_cnt == 8'd0) begin
            if (!rx_s2) begin
              rx_cnt   <= baud_div;
              rx_bit   <= 3'd0;
              rx_state <= RxData;
            end else begin
              rx_state <= RxIdle;
            end
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        RxData: begin
          if (rx_cnt == 8'd0) begin
            rx_sh  <= {rx_s2, rx_sh[7:1]};
            rx_cnt <= baud_div;
            if (rx_bit == 3'd7) rx_state <= RxStop;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
        RxStop: begin
          if (rx_cnt == 8'd0) begin
            // Framing error drops the byte silently.
            if (rx_s2) begin
              rx_data  <= rx_sh;
              rx_valid <= 1'b1;
              if (rx_valid) rx_ovr <= 1'b1;
            end
            rx_state <= RxIdle;
          end else begin
            rx_cnt <= rx_cnt - 8'd1;
          end
        end
      endcase
    end
  end
`else
  logic unused_rx;
  assign unused_rx = uart_rx;
  assign rx_data   = 8'd0;
  assign rx_valid  = 1'b0;
  assign rx_ovr    = 1'b0;
`endif

  assign status = {3'b000, rx_ovr, rx_valid, (tx_state != TxIdle), fifo_empty, fifo_full};

  // Read mux; write-only and out-of-window addresses read zero.
  always_comb begin
    rd_data_pr = 8'd0;
    if (hit) begin
      case (off)
        OFF_STATUS: rd_data_pr = status;
        OFF_RXDATA: rd_data_pr = rx_data;
        OFF_BAUD:   rd_data_pr = baud_div;
        default:    rd_data_pr = 8'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_uart.sv
// Bench for io_uart: register reads, TX framing against a byte scoreboard,
// FIFO full/drop, back-to-back timing, async reset and (with UART_RX_EN) RX.
module tb_io_uart;

  localparam logic [7:0] A_TX = 8'hF0;
  localparam logic [7:0] A_ST = 8'hF1;
  localparam logic [7:0] A_RX = 8'hF2;
  localparam logic [7:0] A_BD = 8'hF3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       wr = 1'b0;
  logic [7:0] rd_data;
  logic       uart_rx;
  logic       uart_tx;
  logic       loop = 1'b0;
  logic       rx_drv = 1'b1;

  int unsigned total = 0;
  int unsigned bad = 0;
  int          cyc = 0;
  int          div_m = 15;
  logic [7:0]  exp_q[$];

  assign uart_rx = loop ? uart_tx : rx_drv;

  io_uart dut (
    .clk         (clk),
    .rst         (rst),
    .addr_bus_pr (addr),
    .wr_data_pr  (wdata),
    .wr_rdn_pr   (wr),
    .rd_data_pr  (rd_data),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [7:0] d, input int n);
    @(negedge clk);
    addr = a; wdata = d; wr = 1'b1;
    repeat (n) @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; wr = 1'b0;
    #1 d = rd_data;
  endtask

  task automatic send(input logic [7:0] d);
    bus_wr(A_TX, d, 1);
    exp_q.push_back(d);
  endtask

  // Waits for a start bit, then checks every level is held div_m+1 cycles.
  task automatic recv_frame(output logic [7:0] b, output bit ok, output int start_cyc);
    int t;
    logic lvl;
    logic s;
    t = 0; b = 8'h00; ok = 1'b0; start_cyc = 0; lvl = 1'b1;
    @(negedge clk);
    while (uart_tx !== 1'b0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (t >= 400) begin
      check("frame_timeout", 0, 1);
      return;
    end
    start_cyc = cyc;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j <= div_m; j++) begin
        if (!(k == 0 && j == 0)) @(negedge clk);
        s = uart_tx;
        if (j == 0) lvl = s;
        else if (s !== lvl) ok = 1'b0;
      end
      if (k == 0 && lvl !== 1'b0) ok = 1'b0;
      if (k == 9 && lvl !== 1'b1) ok = 1'b0;
      if (k >= 1 && k <= 8) b[k-1] = lvl;
    end
  endtask

  task automatic get_frame(input string tag, output int start_cyc);
    logic [7:0] b;
    logic [7:0] e;
    bit ok;
    recv_frame(b, ok, start_cyc);
    check({tag, "_shape"}, {31'd0, ok}, 1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, b, e);
    end
  endtask

  task automatic idle_check(input string tag, input int n);
    bit ok;
    ok = 1'b1;
    repeat (n) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) ok = 1'b0;
    end
    check(tag, {31'd0, ok}, 1);
  endtask

  logic [7:0] r;
  int         st[5];
  int         s0;
  logic [7:0] burst[5] = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A};

  initial begin
    // Reset state and register map.
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, uart_tx}, 1);
    rst = 1'b1;
    bus_rd(A_ST, r); check("rst_status", r, 8'h02);
    bus_rd(A_BD, r); check("rst_baud", r, 8'h0F);
    bus_rd(A_RX, r); check("rst_rxdata", r, 8'h00);
    bus_rd(A_TX, r); check("txdata_wo", r, 8'h00);
    bus_rd(8'h10, r); check("out_of_window", r, 8'h00);
    check("idle_tx", {31'd0, uart_tx}, 1);
    bus_wr(A_ST, 8'hFF, 1);
    bus_rd(A_ST, r); check("status_w1c_ignored", r, 8'h02);

    // Single frame 0xA5 at BAUD_DIV=3, busy across the frame.
    bus_wr(A_BD, 8'h03, 1);
    div_m = 3;
    bus_rd(A_BD, r); check("baud_wr", r, 8'h03);
    send(8'hA5);
    fork
      get_frame("a5", s0);
      begin
        bit busy_ok;
        int t;
        busy_ok = 1'b1; t = 0;
        while (uart_tx !== 1'b0 && t < 400) begin
          @(negedge clk);
          t++;
        end
        for (int i = 0; i < 39; i++) begin
          logic [7:0] sr;
          bus_rd(A_ST, sr);
          if (sr[2] !== 1'b1) busy_ok = 1'b0;
        end
        check("a5_busy", {31'd0, busy_ok}, 1);
      end
    join
    bus_rd(A_ST, r); check("a5_done_status", r, 8'h02);

    // Five 3-cycle writes, then a sixth into a full FIFO.
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          bus_wr(A_TX, burst[i], 3);
          exp_q.push_back(burst[i]);
        end
        bus_rd(A_ST, r); check("burst_full", {31'd0, r[0]}, 1);
        bus_wr(A_TX, 8'hEE, 3);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          get_frame("burst", st[i]);
          if (i > 0) check("b2b_gap", st[i] - st[i-1], 40);
        end
      end
    join
    idle_check("no_dropped_frame", 60);
    bus_rd(A_ST, r); check("burst_done_status", r, 8'h02);
    check("sb_drained", exp_q.size(), 0);

    // One cycle per bit.
    bus_wr(A_BD, 8'h00, 1);
    div_m = 0;
    send(8'hC3);
    get_frame("div0", s0);
    bus_wr(A_BD, 8'h03, 1);
    div_m = 3;

    // Reset asserted during data bit 3.
    bus_wr(A_TX, 8'h00, 1);
    bus_wr(A_TX, 8'h55, 1);
    begin
      int t;
      t = 0;
      while (uart_tx !== 1'b0 && t < 400) begin
        @(negedge clk);
        t++;
      end
      check("rst_frame_seen", {31'd0, (t < 400)}, 1);
    end
    repeat (17) @(negedge clk);
    check("pre_rst_low", {31'd0, uart_tx}, 0);
    rst = 1'b0;
    #1 check("rst_async_tx", {31'd0, uart_tx}, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus_rd(A_ST, r); check("post_rst_status", r, 8'h02);
    bus_rd(A_BD, r); check("post_rst_baud", r, 8'h0F);
    idle_check("post_rst_silent", 100);
    bus_wr(A_BD, 8'h03, 1);
    div_m = 3;

`ifdef UART_RX_EN
    // Loopback receive, overrun, W1C.
    loop = 1'b1;
    send(8'h3C);
    get_frame("rx3c", s0);
    repeat (10) @(negedge clk);
    bus_rd(A_RX, r); check("rx_data_3c", r, 8'h3C);
    bus_rd(A_ST, r); check("rx_valid", {30'd0, r[4:3]}, 2'b01);
    send(8'h7E);
    get_frame("rx7e", s0);
    repeat (10) @(negedge clk);
    bus_rd(A_ST, r); check("rx_ovr", {30'd0, r[4:3]}, 2'b11);
    bus_rd(A_RX, r); check("rx_data_7e", r, 8'h7E);
    bus_wr(A_ST, 8'h18, 1);
    bus_rd(A_ST, r); check("rx_w1c", r, 8'h02);

    // Start glitch and framing error.
    loop = 1'b0;
    @(negedge clk); rx_drv = 1'b0;
    @(negedge clk); rx_drv = 1'b1;
    repeat (40) @(negedge clk);
    bus_rd(A_ST, r); check("rx_glitch", {31'd0, r[3]}, 0);
    begin
      logic [9:0] fr;
      fr = {1'b0, 8'h81, 1'b0};
      for (int k = 0; k < 10; k++) begin
        @(negedge clk); rx_drv = fr[k];
        repeat (3) @(negedge clk);
      end
      @(negedge clk); rx_drv = 1'b1;
    end
    repeat (40) @(negedge clk);
    bus_rd(A_ST, r); check("rx_frame_err", {31'd0, r[3]}, 0);
    bus_rd(A_RX, r); check("rx_frame_err_data", r, 8'h7E);
`else
    // Receive path absent: loopback traffic leaves RX registers at zero.
    loop = 1'b1;
    send(8'h3C);
    get_frame("norx", s0);
    repeat (10) @(negedge clk);
    bus_rd(A_RX, r); check("norx_data", r, 8'h00);
    bus_rd(A_ST, r); check("norx_status", r, 8'h02);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
